// File: rtl/parking_gate_arbiter.sv
// rtl/parking_gate_arbiter.sv - single-gate arbiter between entry and exit lanes with occupancy tracking
//
// Ports:
//   clk         : rising-edge clock
//   reset       : synchronous active-high reset
//   entry_req   : entry lane request (level, held until granted)
//   exit_req    : exit lane request (level, held until granted)
//   entry_grant : one-cycle pulse when an entry pass starts
//   exit_grant  : one-cycle pulse when an exit pass starts
//   gate_open   : high throughout the OPEN phase
//   busy        : high in the OPEN and CLOSE phases
//   dir         : 1 when the current/last pass was entry, 0 for exit
//   done        : one-cycle pulse in the first IDLE cycle after a pass
//   occupancy   : slots in use
//   full/empty  : occupancy at CAPACITY / at zero

module parking_gate_arbiter #(
    parameter int CAPACITY     = 9,
    parameter int OPEN_CYCLES  = 6,
    parameter int CLOSE_CYCLES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       exit_req,
    output logic       entry_grant,
    output logic       exit_grant,
    output logic       gate_open,
    output logic       busy,
    output logic       dir,
    output logic       done,
    output logic [3:0] occupancy,
    output logic       full,
    output logic       empty
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } state_t;

    localparam logic [3:0] CAP        = 4'(CAPACITY);
    localparam logic [3:0] OPEN_LAST  = 4'(OPEN_CYCLES - 1);
    localparam logic [3:0] CLOSE_LAST = 4'(CLOSE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_served_q, last_served_d;  // 1 = entry served last

    logic       entry_ok, exit_ok, pick_entry, start, finish;

    logic       entry_grant_d, exit_grant_d, gate_open_d, busy_d, dir_d, done_d;
    logic       full_d, empty_d;
    logic [3:0] occupancy_d;

    // Eligibility uses the registered occupancy, which has already been
    // updated in the done cycle, so back-to-back passes see the new count.
    assign entry_ok = entry_req && (occupancy < CAP);
    assign exit_ok  = exit_req && (occupancy != 4'd0);

    // Round-robin only matters when both lanes are eligible.
    assign pick_entry = (entry_ok && exit_ok) ? !last_served_q : entry_ok;

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            last_served_q <= 1'b1;
            entry_grant   <= 1'b0;
            exit_grant    <= 1'b0;
            gate_open     <= 1'b0;
            busy          <= 1'b0;
            dir           <= 1'b0;
            done          <= 1'b0;
            occupancy     <= 4'd0;
            full          <= 1'b0;
            empty         <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_served_q <= last_served_d;
            entry_grant   <= entry_grant_d;
            exit_grant    <= exit_grant_d;
            gate_open     <= gate_open_d;
            busy          <= busy_d;
            dir           <= dir_d;
            done          <= done_d;
            occupancy     <= occupancy_d;
            full          <= full_d;
            empty         <= empty_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (entry_ok || exit_ok) begin
                    state_d = OPEN;
                    cnt_d   = 4'd0;
                    start   = 1'b1;
                end
            end
            OPEN: begin
                if (cnt_q == OPEN_LAST) begin
                    state_d = CLOSE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CLOSE: begin
                if (cnt_q == CLOSE_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        finish        = (state_q == CLOSE) && (state_d == IDLE);
        entry_grant_d = start && pick_entry;
        exit_grant_d  = start && !pick_entry;
        gate_open_d   = (state_d == OPEN);
        busy_d        = (state_d != IDLE);
        done_d        = finish;
        dir_d         = start ? pick_entry : dir;
        last_served_d = start ? pick_entry : last_served_q;
        occupancy_d   = occupancy;
        // Bounds are re-checked here so occupancy can never leave 0..CAPACITY.
        if (finish) begin
            if (dir && (occupancy < CAP)) begin
                occupancy_d = occupancy + 4'd1;
            end else if (!dir && (occupancy != 4'd0)) begin
                occupancy_d = occupancy - 4'd1;
            end
        end
        full_d  = (occupancy_d == CAP);
        empty_d = (occupancy_d == 4'd0);
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb/tb_parking_gate_arbiter.sv - directed self-checking bench for parking_gate_arbiter

module tb_parking_gate_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       entry_req;
    logic       exit_req;
    logic       entry_grant;
    logic       exit_grant;
    logic       gate_open;
    logic       busy;
    logic       dir;
    logic       done;
    logic [3:0] occupancy;
    logic       full;
    logic       empty;

    int vectors     = 0;
    int miscompares = 0;

    parking_gate_arbiter #(
        .CAPACITY    (9),
        .OPEN_CYCLES (6),
        .CLOSE_CYCLES(6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .entry_req  (entry_req),
        .exit_req   (exit_req),
        .entry_grant(entry_grant),
        .exit_grant (exit_grant),
        .gate_open  (gate_open),
        .busy       (busy),
        .dir        (dir),
        .done       (done),
        .occupancy  (occupancy),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Drives one request until granted, then drops it; waits (bounded) for done.
    task automatic run_pass(input bit is_entry, output int g_cyc, output int d_cyc, output bit g_entry);
        g_cyc   = -1;
        d_cyc   = -1;
        g_entry = 1'b0;
        if (is_entry) entry_req = 1'b1;
        else          exit_req  = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (entry_grant || exit_grant) begin
                if (g_cyc < 0) begin
                    g_cyc   = c;
                    g_entry = entry_grant;
                end
                entry_req = 1'b0;
                exit_req  = 1'b0;
            end
            if (done) begin
                d_cyc = c;
                break;
            end
        end
        entry_req = 1'b0;
        exit_req  = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        entry_req = 1'b1;
        exit_req  = 1'b1;
        tick();
        tick();
        vectors++;
        if ({entry_grant, exit_grant, gate_open, busy, done} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b expected 00000", {entry_grant, exit_grant, gate_open, busy, done});
        end
        vectors++;
        if (occupancy !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_occupancy got %0d expected 0", occupancy);
        end
        vectors++;
        if ({full, empty, dir} !== 3'b010) begin
            miscompares++;
            $display("FAIL reset_flags {full,empty,dir} got %b expected 010", {full, empty, dir});
        end
        entry_req = 1'b0;
        exit_req  = 1'b0;
        reset     = 1'b0;
        tick();
    endtask

    // Entry request held through the pass: grant must still be a single pulse.
    task automatic test_single_entry();
        logic [4:0] exp;
        entry_req = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            exp = {(c == 1), 1'b0, (c <= 6), (c <= 12), (c == 13)};
            vectors++;
            if ({entry_grant, exit_grant, gate_open, busy, done} !== exp) begin
                miscompares++;
                $display("FAIL single_entry_c%0d {eg,xg,open,busy,done} got %b expected %b",
                         c, {entry_grant, exit_grant, gate_open, busy, done}, exp);
            end
            if (c == 1) begin
                vectors++;
                if (dir !== 1'b1) begin
                    miscompares++;
                    $display("FAIL single_entry_dir got %b expected 1", dir);
                end
            end
            if (c == 13) entry_req = 1'b0;
        end
        vectors++;
        if ({occupancy, full, empty} !== {4'd1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL single_entry_occ {occ,full,empty} got %0d %b %b expected 1 0 0", occupancy, full, empty);
        end
        tick();
        vectors++;
        if ({entry_grant, busy, occupancy} !== {1'b0, 1'b0, 4'd1}) begin
            miscompares++;
            $display("FAIL single_entry_after {eg,busy,occ} got %b %b %0d expected 0 0 1", entry_grant, busy, occupancy);
        end
    endtask

    task automatic test_drop_after_grant();
        int g, d;
        bit ge;
        run_pass(1'b1, g, d, ge);
        vectors++;
        if ({g, d} !== {32'sd1, 32'sd13} || ge !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_after_grant grant_cyc %0d done_cyc %0d entry %b expected 1 13 1", g, d, ge);
        end
        vectors++;
        if (occupancy !== 4'd2) begin
            miscompares++;
            $display("FAIL drop_after_grant_occ got %0d expected 2", occupancy);
        end
    endtask

    task automatic test_contested();
        int g, d, first, second, n_entry, n_exit;
        bit ge;
        do_reset();
        for (int i = 0; i < 3; i++) run_pass(1'b1, g, d, ge);
        vectors++;
        if (occupancy !== 4'd3) begin
            miscompares++;
            $display("FAIL contested_setup_occ got %0d expected 3", occupancy);
        end
        first = -1; second = -1; n_entry = 0; n_exit = 0;
        entry_req = 1'b1;
        exit_req  = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (exit_grant) begin
                n_exit++;
                if (first < 0) first = c;
                exit_req = 1'b0;
                vectors++;
                if ({entry_grant, dir} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL contested_exit_dir {eg,dir} got %b expected 00", {entry_grant, dir});
                end
            end
            if (entry_grant) begin
                n_entry++;
                if (second < 0) second = c;
                entry_req = 1'b0;
                vectors++;
                if (dir !== 1'b1) begin
                    miscompares++;
                    $display("FAIL contested_entry_dir got %b expected 1", dir);
                end
            end
        end
        entry_req = 1'b0;
        exit_req  = 1'b0;
        vectors++;
        if (first !== 1 || second !== 14 || n_entry !== 1 || n_exit !== 1) begin
            miscompares++;
            $display("FAIL contested_order exit_at %0d entry_at %0d n_exit %0d n_entry %0d expected 1 14 1 1",
                     first, second, n_exit, n_entry);
        end
        vectors++;
        if (occupancy !== 4'd3) begin
            miscompares++;
            $display("FAIL contested_final_occ got %0d expected 3", occupancy);
        end
    endtask

    task automatic test_full();
        int g, d, grants, egr;
        bit ge;
        do_reset();
        for (int i = 0; i < 9; i++) run_pass(1'b1, g, d, ge);
        vectors++;
        if ({occupancy, full, empty} !== {4'd9, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL full_setup {occ,full,empty} got %0d %b %b expected 9 1 0", occupancy, full, empty);
        end
        grants = 0;
        entry_req = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (entry_grant || exit_grant || busy) grants++;
        end
        vectors++;
        if (grants !== 0 || occupancy !== 4'd9) begin
            miscompares++;
            $display("FAIL full_entry_blocked activity %0d occ %0d expected 0 9", grants, occupancy);
        end
        g = -1; d = -1; egr = 0;
        exit_req = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (entry_grant) egr++;
            if (exit_grant && g < 0) begin
                g = c;
                exit_req  = 1'b0;
                entry_req = 1'b0;
            end
            if (done) begin
                d = c;
                break;
            end
        end
        entry_req = 1'b0;
        exit_req  = 1'b0;
        vectors++;
        if (g !== 1 || d !== 13 || egr !== 0) begin
            miscompares++;
            $display("FAIL full_exit grant_cyc %0d done_cyc %0d entry_grants %0d expected 1 13 0", g, d, egr);
        end
        vectors++;
        if ({occupancy, full} !== {4'd8, 1'b0}) begin
            miscompares++;
            $display("FAIL full_exit_occ {occ,full} got %0d %b expected 8 0", occupancy, full);
        end
    endtask

    task automatic test_empty();
        int act;
        do_reset();
        act = 0;
        exit_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (entry_grant || exit_grant || busy || done) act++;
        end
        exit_req = 1'b0;
        vectors++;
        if (act !== 0 || {occupancy, empty} !== {4'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL empty_exit_blocked activity %0d occ %0d empty %b expected 0 0 1", act, occupancy, empty);
        end
    endtask

    task automatic test_reset_mid_pass();
        int dn;
        do_reset();
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        vectors++;
        if (entry_grant !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_grant got %b expected 1", entry_grant);
        end
        tick(); tick(); tick();
        vectors++;
        if ({gate_open, busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL mid_reset_open_c4 {open,busy} got %b expected 11", {gate_open, busy});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({gate_open, busy, done, occupancy, empty} !== {3'b000, 4'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_reset_abort {open,busy,done} %b occ %0d empty %b expected 000 0 1",
                     {gate_open, busy, done}, occupancy, empty);
        end
        dn = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (done || busy) dn++;
        end
        vectors++;
        if (dn !== 0 || occupancy !== 4'd0) begin
            miscompares++;
            $display("FAIL mid_reset_no_done activity %0d occ %0d expected 0 0", dn, occupancy);
        end
    endtask

    initial begin
        reset     = 1'b1;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        test_reset();
        test_single_entry();
        test_drop_after_grant();
        test_contested();
        test_full();
        test_empty();
        test_reset_mid_pass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
